// File: rtl/iic_pkg.sv
// Shared I2C definitions: FSM state encoding, acknowledge levels and byte width.
package iic_pkg;

   localparam int   BYTE_W = 8;
   localparam logic ACK    = 1'b0;
   localparam logic NACK   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_RX,
      ST_RX_ACK,
      ST_TX,
      ST_TX_ACK,
      ST_WAIT_STOP
   } state_t;

endpackage

// File: rtl/iic_line_sync.sv
// Synchronizes the SCK and SDA pad levels into the system clock domain and
// flags their rising and falling edges from a one-flop history.
module iic_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic sck_in,
   input  logic sda_in,
   output logic sck,
   output logic sda,
   output logic sck_rise,
   output logic sck_fall,
   output logic sda_rise,
   output logic sda_fall
);

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   sck_prev;
   logic                   sda_prev;

   // Synchronizer chains plus history flops for edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: reset to 1, the idle bus level, so leaving reset on a quiet bus sees no edge.
         sck_sync <= '1;
         sda_sync <= '1;
         sck_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments keep every stage one clock behind the previous one.
         sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
         sck_prev <= sck_sync[SYNC_STAGES-1];
         sda_prev <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign sck      = sck_sync[SYNC_STAGES-1];
   assign sda      = sda_sync[SYNC_STAGES-1];
   assign sck_rise =  sck & ~sck_prev;
   assign sck_fall = ~sck &  sck_prev;
   assign sda_rise =  sda & ~sda_prev;
   assign sda_fall = ~sda &  sda_prev;

endmodule

// File: rtl/iic_target.sv
// I2C target: matches a 7-bit address, receives write bytes and serves read
// bytes from local logic. SDA is only ever pulled low (open-drain enable).
module iic_target
   import iic_pkg::*;
#(
   parameter logic [6:0] ADDR        = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              sck_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic              busy,
   output logic              rw,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [BYTE_W-1:0] tx_data,
   output logic              tx_req,
   output logic              start_det,
   output logic              stop_det
);

   logic              sck, sda, sck_rise, sck_fall, sda_rise, sda_fall;
   logic              start_cond, stop_cond;
   state_t            state;
   logic [2:0]        bit_cnt;
   logic [BYTE_W-1:0] shreg;
   logic              pend;   // 8th bit taken, acknowledge due at next SCK fall
   logic              nack;   // initiator answered the last read byte with NACK

   iic_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock    (clock),
      .reset_n  (reset_n),
      .sck_in   (sck_in),
      .sda_in   (sda_in),
      .sck      (sck),
      .sda      (sda),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .sda_rise (sda_rise),
      .sda_fall (sda_fall)
   );

   // SDA moving while SCK is high marks bus conditions rather than data.
   assign start_cond = sda_fall & sck;
   assign stop_cond  = sda_rise & sck;

   // Protocol FSM with bit counter, shift register and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         pend      <= 1'b0;
         nack      <= 1'b0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         rw        <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low here so each branch only states when they fire.
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         if (start_cond) begin
            state     <= ST_ADDR;
            bit_cnt   <= '0;
            pend      <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b1;
            start_det <= 1'b1;
         end else if (stop_cond) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            pend     <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            stop_det <= 1'b1;
         end else begin
            case (state)
               ST_ADDR: begin
                  if (sck_rise && !pend) begin
                     shreg   <= {shreg[BYTE_W-2:0], sda};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        // Address is the seven bits already shifted in; sda is R/W.
                        if (shreg[6:0] == ADDR) begin
                           rw   <= sda;
                           pend <= 1'b1;
                        end else begin
                           state <= ST_WAIT_STOP;
                           busy  <= 1'b0;
                        end
                     end
                  end else if (sck_fall && pend) begin
                     pend   <= 1'b0;
                     sda_oe <= (ACK == 1'b0);
                     state  <= ST_ADDR_ACK;
                  end
               end
               ST_ADDR_ACK: begin
                  if (sck_fall) begin
                     if (rw) begin
                        shreg   <= tx_data;
                        tx_req  <= 1'b1;
                        sda_oe  <= ~tx_data[BYTE_W-1];
                        bit_cnt <= '0;
                        state   <= ST_TX;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= ST_RX;
                     end
                  end
               end
               ST_RX: begin
                  if (sck_rise && !pend) begin
                     shreg   <= {shreg[BYTE_W-2:0], sda};
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        rx_data  <= {shreg[BYTE_W-2:0], sda};
                        rx_valid <= 1'b1;
                        pend     <= 1'b1;
                     end
                  end else if (sck_fall && pend) begin
                     pend   <= 1'b0;
                     sda_oe <= (ACK == 1'b0);
                     state  <= ST_RX_ACK;
                  end
               end
               ST_RX_ACK: begin
                  if (sck_fall) begin
                     sda_oe <= 1'b0;
                     state  <= ST_RX;
                  end
               end
               ST_TX: begin
                  if (sck_fall) begin
                     if (bit_cnt == 3'd7) begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= ST_TX_ACK;
                     end else begin
                        sda_oe  <= ~shreg[BYTE_W-2];
                        shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               ST_TX_ACK: begin
                  if (sck_rise) begin
                     nack <= (sda == NACK);
                  end else if (sck_fall) begin
                     if (!nack) begin
                        shreg   <= tx_data;
                        tx_req  <= 1'b1;
                        sda_oe  <= ~tx_data[BYTE_W-1];
                        bit_cnt <= '0;
                        state   <= ST_TX;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= ST_WAIT_STOP;
                     end
                  end
               end
               default: begin
                  // IDLE and WAIT_STOP ignore SCK until a START or STOP.
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iic_target.sv
// Directed bench for iic_target: an initiator bus model drives SCK/SDA on an
// open-drain wired-AND bus with pull-ups; each task checks its own scenario.
module tb_iic_target;

   localparam int Q = 8;   // system clocks per quarter SCK period

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       sck_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sck_in, sda_in;
   logic       sda_oe, busy, rw, rx_valid, tx_req, start_det, stop_det;
   logic [7:0] rx_data;
   logic [7:0] tx_data = 8'h00;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor counters, written only by the monitor process.
   int         n_rx = 0, n_tx = 0, n_start = 0, n_stop = 0, n_viol = 0;
   logic [7:0] last_rx = 8'h00;
   logic       prev_oe = 1'b0;

   always #5 clock = ~clock;

   assign sck_in = sck_m;
   assign sda_in = sda_m & ~sda_oe;

   iic_target dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .sck_in    (sck_in),
      .sda_in    (sda_in),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .rw        (rw),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .tx_data   (tx_data),
      .tx_req    (tx_req),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   always @(negedge clock) begin
      if (rx_valid) begin
         n_rx++;
         last_rx = rx_data;
      end
      if (tx_req)    n_tx++;
      if (start_det) n_start++;
      if (stop_det)  n_stop++;
      if (reset_n && sck_in && (sda_oe != prev_oe)) n_viol++;
      prev_oe = sda_oe;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- bus model ----------------
   task automatic wait_q();
      repeat (Q) @(negedge clock);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; sck_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      sck_m = 1'b0; wait_q();
   endtask

   task automatic bus_rstart();
      sda_m = 1'b1; wait_q();
      sck_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      sck_m = 1'b0; wait_q();
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; wait_q();
      sck_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; wait_q();
      sck_m = 1'b1; wait_q(); wait_q();
      sck_m = 1'b0; wait_q();
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_q();
      sck_m = 1'b1; wait_q();
      b = sda_in; wait_q();
      sck_m = 1'b0; wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(ack);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b0; sck_m = 1'b1; sda_m = 1'b1;
      repeat (4) @(negedge clock);
      n_checks++;
      if ({sda_oe, busy, rw, rx_valid, tx_req, start_det, stop_det} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b required 0000000",
                  {sda_oe, busy, rw, rx_valid, tx_req, start_det, stop_det});
      end
      n_checks++;
      if (rx_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_rx_data: got %h required 00", rx_data);
      end
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
   endtask

   task automatic test_write();
      logic a0, a1;
      int   s_rx = n_rx, s_start = n_start, s_stop = n_stop;
      bus_start();
      write_byte(8'hA0, a0);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b required 1", busy); end
      write_byte(8'h3C, a1);
      bus_stop();
      n_checks++;
      if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL wr_acks: got %b required 00", {a0, a1}); end
      n_checks++;
      if (n_rx - s_rx != 1) begin n_fail++; $display("FAIL wr_rx_pulses: got %0d required 1", n_rx - s_rx); end
      n_checks++;
      if (last_rx !== 8'h3C) begin n_fail++; $display("FAIL wr_rx_data: got %h required 3c", last_rx); end
      n_checks++;
      if (n_start - s_start != 1) begin n_fail++; $display("FAIL wr_start: got %0d required 1", n_start - s_start); end
      n_checks++;
      if (n_stop - s_stop != 1) begin n_fail++; $display("FAIL wr_stop: got %0d required 1", n_stop - s_stop); end
      n_checks++;
      if ({busy, rw} !== 2'b00) begin n_fail++; $display("FAIL wr_busy_rw_end: got %b required 00", {busy, rw}); end
   endtask

   task automatic test_addr_mismatch();
      logic a0, a1;
      int   s_rx = n_rx;
      bus_start();
      write_byte(8'hA2, a0);
      n_checks++;
      if (a0 !== 1'b1) begin n_fail++; $display("FAIL mis_nack: got %b required 1", a0); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mis_busy: got %b required 0", busy); end
      write_byte(8'h77, a1);
      n_checks++;
      if (a1 !== 1'b1) begin n_fail++; $display("FAIL mis_data_ignored: got %b required 1", a1); end
      bus_stop();
      n_checks++;
      if (n_rx != s_rx) begin n_fail++; $display("FAIL mis_rx_pulses: got %0d required 0", n_rx - s_rx); end
   endtask

   task automatic test_read();
      logic       a0;
      logic [7:0] d0, d1;
      int         s_tx = n_tx;
      tx_data = 8'hA5;
      bus_start();
      write_byte(8'hA1, a0);
      tx_data = 8'h5A;
      read_byte(d0, 1'b0);
      read_byte(d1, 1'b1);
      n_checks++;
      if (a0 !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack: got %b required 0", a0); end
      n_checks++;
      if (rw !== 1'b1) begin n_fail++; $display("FAIL rd_rw: got %b required 1", rw); end
      n_checks++;
      if (d0 !== 8'hA5) begin n_fail++; $display("FAIL rd_byte0: got %h required a5", d0); end
      n_checks++;
      if (d1 !== 8'h5A) begin n_fail++; $display("FAIL rd_byte1: got %h required 5a", d1); end
      n_checks++;
      if (n_tx - s_tx != 2) begin n_fail++; $display("FAIL rd_tx_req: got %0d required 2", n_tx - s_tx); end
      n_checks++;
      if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rd_release: got %b required 0", sda_oe); end
      bus_stop();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_end: got %b required 0", busy); end
   endtask

   task automatic test_repeated_start();
      logic       a0, a1, a2;
      logic [7:0] d0;
      int         s_start = n_start;
      tx_data = 8'hC3;
      bus_start();
      write_byte(8'hA0, a0);
      write_byte(8'h11, a1);
      n_checks++;
      if (rw !== 1'b0) begin n_fail++; $display("FAIL rs_rw_write: got %b required 0", rw); end
      bus_rstart();
      write_byte(8'hA1, a2);
      read_byte(d0, 1'b1);
      bus_stop();
      n_checks++;
      if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL rs_acks: got %b required 000", {a0, a1, a2}); end
      n_checks++;
      if (n_start - s_start != 2) begin n_fail++; $display("FAIL rs_start: got %0d required 2", n_start - s_start); end
      n_checks++;
      if (rw !== 1'b1) begin n_fail++; $display("FAIL rs_rw_read: got %b required 1", rw); end
      n_checks++;
      if (d0 !== 8'hC3) begin n_fail++; $display("FAIL rs_read_data: got %h required c3", d0); end
      n_checks++;
      if (rx_data !== 8'h11) begin n_fail++; $display("FAIL rs_rx_data: got %h required 11", rx_data); end
   endtask

   task automatic test_reset_mid_ack();
      logic       a0, a1, a2;
      logic [7:0] v = 8'h96;
      bus_start();
      write_byte(8'hA0, a0);
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      n_checks++;
      if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_ack_driven: got %b required 1", sda_oe); end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({sda_oe, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_release: got %b required 00", {sda_oe, busy}); end
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      sda_m = 1'b1; wait_q();
      sck_m = 1'b1; wait_q();
      bus_start();
      write_byte(8'hA0, a1);
      write_byte(8'h5E, a2);
      bus_stop();
      n_checks++;
      if ({a1, a2} !== 2'b00) begin n_fail++; $display("FAIL rst_after_acks: got %b required 00", {a1, a2}); end
      n_checks++;
      if (rx_data !== 8'h5E) begin n_fail++; $display("FAIL rst_after_data: got %h required 5e", rx_data); end
   endtask

   task automatic test_stop_mid_byte();
      logic a0;
      int   s_rx = n_rx, s_stop = n_stop;
      bus_start();
      write_byte(8'hA0, a0);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
      bus_stop();
      n_checks++;
      if (n_rx != s_rx) begin n_fail++; $display("FAIL smb_rx_pulses: got %0d required 0", n_rx - s_rx); end
      n_checks++;
      if ({busy, sda_oe} !== 2'b00) begin n_fail++; $display("FAIL smb_idle: got %b required 00", {busy, sda_oe}); end
      n_checks++;
      if (n_stop - s_stop != 1) begin n_fail++; $display("FAIL smb_stop: got %0d required 1", n_stop - s_stop); end
      n_checks++;
      if (rx_data !== 8'h5E) begin n_fail++; $display("FAIL smb_rx_kept: got %h required 5e", rx_data); end
   endtask

   task automatic test_oe_timing();
      n_checks++;
      if (n_viol != 0) begin n_fail++; $display("FAIL oe_while_sck_high: got %0d changes required 0", n_viol); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_addr_mismatch();
      test_read();
      test_repeated_start();
      test_reset_mid_ack();
      test_stop_mid_byte();
      test_oe_timing();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
